// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the MIPS single-cycle front end.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  OP_RTYPE         = 6'b000000;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_BEQ           = 6'b000100;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Instruction-memory req/ack fetch bus.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_logic
// Brief    : Combinational next-PC select: jump, taken branch or PC+4.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_logic (
  input  wire  [31:0] PCPlus4,
  input  wire  [31:0] Instr,
  input  wire         Jump,
  input  wire         Branch,
  input  wire         Zero,
  output logic [31:0] NextPC
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic        w_unused_op;

  assign w_jump_target   = {PCPlus4[31:28], Instr[25:0], 2'b00};
  assign w_branch_target = PCPlus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
  assign w_unused_op     = ^Instr[31:26];

  // Jump is tested first so an unknown Branch never reaches NextPC.
  always_comb begin
    NextPC = PCPlus4;
    if (Jump) begin
      NextPC = w_jump_target;
    end else if (Branch && Zero) begin
      NextPC = w_branch_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch FSM, PC and instruction register with fetch timeout.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 15
) (
  input  wire                       clk,
  input  wire                       rst,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               Instr,
  output logic [5:0]                OP,
  output logic [5:0]                Funct,
  output logic                      InstrValid,
  input  wire                       ExecDone,
  input  wire                       Jump,
  input  wire                       Branch,
  input  wire                       Zero,
  output logic [31:0]               PC,
  output logic [31:0]               PCPlus4,
  output logic                      ImemErr
);

  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_next;
  logic [7:0]   r_wait_cnt;
  logic [7:0]   w_wait_cnt_next;
  logic [31:0]  w_next_pc;

  assign PC             = r_pc;
  assign PCPlus4        = r_pc + 32'd4;
  assign Instr          = r_instr;
  assign OP             = r_instr[31:26];
  assign Funct          = r_instr[5:0];
  assign imem.imem_addr = r_pc;

  next_pc_logic u_next_pc (
    .PCPlus4 (PCPlus4),
    .Instr   (r_instr),
    .Jump    (Jump),
    .Branch  (Branch),
    .Zero    (Zero),
    .NextPC  (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Outputs decode from state only, so reset drops imem_req without a clock.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_wait_cnt_next = r_wait_cnt;
    imem.imem_req   = 1'b0;
    InstrValid      = 1'b0;
    ImemErr         = 1'b0;
    case (r_state)
      S_RESET: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          w_instr_next    = imem.imem_rdata;
          w_wait_cnt_next = '0;
          w_state_next    = S_EXEC;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
          if (w_wait_cnt_next == c_TIMEOUT) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_EXEC: begin
        InstrValid = 1'b1;
        if (ExecDone) begin
          w_pc_next    = w_next_pc;
          w_state_next = S_FETCH;
        end
      end
      S_ERR: begin
        ImemErr = 1'b1;
      end
      default: begin
        w_state_next = S_RESET;
      end
    endcase
  end

endmodule
`default_nettype wire
